// File: rtl/jace_ps2_keyboard.sv
// PS/2 set-2 keyboard front end for the Jupiter Ace.
// Receives scan-code frames, tracks make/break/extended prefixes and keeps
// the 8x5 key matrix that the Ace reads back on an I/O read of port FE.
//
// Receiver FSM
//   state     | meaning
//   RX_IDLE   | waiting for a start bit (sampled 0)
//   RX_DATA   | shifting in 8 data bits, LSB first
//   RX_PARITY | sampling the odd-parity bit
//   RX_STOP   | sampling the stop bit, then strobe code or error
//
// Decoder FSM
//   state     | meaning
//   DEC_NORM  | no prefix pending
//   DEC_BRK   | F0 seen, next key byte is a release
//   DEC_EXT   | E0 seen, next key byte is an extended make
//   DEC_EXTBRK| E0 F0 seen, next key byte is an extended release
module jace_ps2_keyboard #(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] row_sel_n,
    output logic [4:0] kbdcols,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        DEC_NORM,
        DEC_BRK,
        DEC_EXT,
        DEC_EXTBRK
    } dec_state_t;

    logic          clk_s1;
    logic          clk_s2;
    logic          dat_s1;
    logic          dat_s2;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          ps2_fall;

    rx_state_t     rx_state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] to_cnt;

    dec_state_t    dec_state;
    logic [39:0]   matrix;
    logic          key_ext;
    logic [6:0]    key_map;

    // Scan code to matrix index (row*5 + col); bit 6 flags a mapped key.
    function automatic logic [6:0] map_key(input logic ext, input logic [7:0] sc);
        logic [6:0] m;
        m = 7'd0;
        if (ext) begin
            if (sc == 8'h14) m = {1'b1, 6'd1};
        end else begin
            case (sc)
                8'h12, 8'h59: m = {1'b1, 6'd0};   // SHIFT
                8'h14:        m = {1'b1, 6'd1};   // SYMSHIFT
                8'h1A:        m = {1'b1, 6'd2};   // Z
                8'h22:        m = {1'b1, 6'd3};   // X
                8'h21:        m = {1'b1, 6'd4};   // C
                8'h1C:        m = {1'b1, 6'd5};   // A
                8'h1B:        m = {1'b1, 6'd6};   // S
                8'h23:        m = {1'b1, 6'd7};   // D
                8'h2B:        m = {1'b1, 6'd8};   // F
                8'h34:        m = {1'b1, 6'd9};   // G
                8'h15:        m = {1'b1, 6'd10};  // Q
                8'h1D:        m = {1'b1, 6'd11};  // W
                8'h24:        m = {1'b1, 6'd12};  // E
                8'h2D:        m = {1'b1, 6'd13};  // R
                8'h2C:        m = {1'b1, 6'd14};  // T
                8'h16:        m = {1'b1, 6'd15};  // 1
                8'h1E:        m = {1'b1, 6'd16};  // 2
                8'h26:        m = {1'b1, 6'd17};  // 3
                8'h25:        m = {1'b1, 6'd18};  // 4
                8'h2E:        m = {1'b1, 6'd19};  // 5
                8'h45:        m = {1'b1, 6'd20};  // 0
                8'h46:        m = {1'b1, 6'd21};  // 9
                8'h3E:        m = {1'b1, 6'd22};  // 8
                8'h3D:        m = {1'b1, 6'd23};  // 7
                8'h36:        m = {1'b1, 6'd24};  // 6
                8'h4D:        m = {1'b1, 6'd25};  // P
                8'h44:        m = {1'b1, 6'd26};  // O
                8'h43:        m = {1'b1, 6'd27};  // I
                8'h3C:        m = {1'b1, 6'd28};  // U
                8'h35:        m = {1'b1, 6'd29};  // Y
                8'h5A:        m = {1'b1, 6'd30};  // ENTER
                8'h4B:        m = {1'b1, 6'd31};  // L
                8'h42:        m = {1'b1, 6'd32};  // K
                8'h3B:        m = {1'b1, 6'd33};  // J
                8'h33:        m = {1'b1, 6'd34};  // H
                8'h29:        m = {1'b1, 6'd35};  // SPACE
                8'h3A:        m = {1'b1, 6'd36};  // M
                8'h31:        m = {1'b1, 6'd37};  // N
                8'h32:        m = {1'b1, 6'd38};  // B
                8'h2A:        m = {1'b1, 6'd39};  // V
                default:      m = 7'd0;
            endcase
        end
        return m;
    endfunction

    // Two-flop synchronisers on both pins, then a glitch filter on the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // The filtered clock is about to drop: this is the data sampling point.
    assign ps2_fall = clk_filt && !clk_s2 && (filt_cnt == FW'(FILTER_LEN - 1));

    // Frame receiver with an idle timeout that abandons partial frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par_ok     <= 1'b0;
            to_cnt     <= '0;
            code       <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (ps2_fall) begin
                to_cnt <= '0;
                case (rx_state)
                    RX_IDLE: begin
                        if (!dat_s2) begin
                            rx_state <= RX_DATA;
                            bit_cnt  <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) rx_state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par_ok   <= (^shreg) ^ dat_s2;
                        rx_state <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (dat_s2 && par_ok) begin
                            code       <= shreg;
                            code_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end else if (rx_state == RX_IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                to_cnt    <= '0;
                rx_state  <= RX_IDLE;
                frame_err <= 1'b1;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    // Lookup uses the prefix state so E0-prefixed bytes only hit right ctrl.
    always_comb begin
        key_ext = (dec_state == DEC_EXT) || (dec_state == DEC_EXTBRK);
        key_map = map_key(key_ext, code);
    end

    // Prefix decoder and key matrix; repeats and stray releases are idempotent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_state <= DEC_NORM;
            matrix    <= 40'd0;
        end else if (frame_err) begin
            dec_state <= DEC_NORM;
        end else if (code_valid) begin
            case (dec_state)
                DEC_NORM: begin
                    if (code == 8'hF0) begin
                        dec_state <= DEC_BRK;
                    end else if (code == 8'hE0) begin
                        dec_state <= DEC_EXT;
                    end else begin
                        if (key_map[6]) matrix[key_map[5:0]] <= 1'b1;
                        dec_state <= DEC_NORM;
                    end
                end
                DEC_EXT: begin
                    if (code == 8'hF0) begin
                        dec_state <= DEC_EXTBRK;
                    end else begin
                        if (key_map[6]) matrix[key_map[5:0]] <= 1'b1;
                        dec_state <= DEC_NORM;
                    end
                end
                DEC_BRK, DEC_EXTBRK: begin
                    if (key_map[6]) matrix[key_map[5:0]] <= 1'b0;
                    dec_state <= DEC_NORM;
                end
                default: dec_state <= DEC_NORM;
            endcase
        end
    end

    // Column read-back: any selected row with the key down pulls its column low.
    always_comb begin
        kbdcols = 5'b11111;
        for (int c = 0; c < 5; c++) begin
            for (int r = 0; r < 8; r++) begin
                if (matrix[r*5 + c] && !row_sel_n[r]) kbdcols[c] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jace_ps2_keyboard.sv
// Self-checking bench for jace_ps2_keyboard: PS/2 frames are bit-banged on
// the pins, expected strobes go into a scoreboard queue and are popped as
// the DUT strobes; matrix state is checked through kbdcols.
module tb_jace_ps2_keyboard;

    localparam int TO_CYC = 1000;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] row_sel_n;
    logic [4:0] kbdcols;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;

    // {valid, err, code}
    logic [9:0] exp_q[$];

    jace_ps2_keyboard #(
        .TIMEOUT_CYCLES(TO_CYC),
        .FILTER_LEN    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .row_sel_n (row_sel_n),
        .kbdcols   (kbdcols),
        .code      (code),
        .code_valid(code_valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock step; strobes seen on the falling edge are scored here.
    task automatic tick();
        logic [9:0] obs;
        logic [9:0] exp;
        @(negedge clk);
        if (code_valid || frame_err) begin
            n_valid += int'(code_valid);
            n_err   += int'(frame_err);
            obs = {code_valid, frame_err, (code_valid ? code : 8'h00)};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got valid=%0b err=%0b code=%02h, expected no strobe",
                         code_valid, frame_err, code);
            end else begin
                exp = exp_q.pop_front();
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL strobe: got valid/err/code=%0b/%0b/%02h, expected %0b/%0b/%02h",
                             obs[9], obs[8], obs[7:0], exp[9], exp[8], exp[7:0]);
                end
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cycles(10);
        ps2_clk = 1'b0;
        wait_cycles(20);
        ps2_clk = 1'b1;
        wait_cycles(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_parity);
        logic p;
        p = ~(^b);
        if (bad_parity) begin
            p = ~p;
            exp_q.push_back({1'b0, 1'b1, 8'h00});
        end else begin
            exp_q.push_back({1'b1, 1'b0, b});
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        ps2_data = 1'b1;
    endtask

    task automatic drain(input int limit, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            tick();
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d strobes outstanding after %0d cycles, expected 0",
                     name, exp_q.size(), limit);
            exp_q.delete();
        end
        wait_cycles(3);
    endtask

    task automatic test_reset();
        logic [7:0] sels[3];
        sels[0] = 8'hFF; sels[1] = 8'h00; sels[2] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            row_sel_n = sels[i];
            #1;
            checks++;
            if (kbdcols !== 5'b11111) begin
                errors++;
                $display("FAIL reset_cols sel=%02h: got %05b, expected 11111", sels[i], kbdcols);
            end
        end
        checks++;
        if (code !== 8'h00 || code_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outs: got code=%02h valid=%0b err=%0b, expected 00/0/0",
                     code, code_valid, frame_err);
        end
        row_sel_n = 8'hFF;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(5);
    endtask

    task automatic test_cols(input logic [7:0] sel, input logic [4:0] exp, input string name);
        row_sel_n = sel;
        #1;
        checks++;
        if (kbdcols !== exp) begin
            errors++;
            $display("FAIL %s sel=%02h: got %05b, expected %05b", name, sel, kbdcols, exp);
        end
    endtask

    task automatic test_make_a();
        send_frame(8'h1C, 1'b0);
        drain(100, "make_a");
        checks++;
        if (code !== 8'h1C) begin
            errors++;
            $display("FAIL make_a_code: got %02h, expected 1c", code);
        end
        test_cols(8'hFD, 5'b11110, "make_a_row1");
        test_cols(8'hFF, 5'b11111, "make_a_none");
    endtask

    task automatic test_break_a();
        int v0;
        v0 = n_valid;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        drain(100, "break_a");
        checks++;
        if (n_valid - v0 != 2) begin
            errors++;
            $display("FAIL break_a_strobes: got %0d, expected 2", n_valid - v0);
        end
        test_cols(8'hFD, 5'b11111, "break_a_row1");
    endtask

    task automatic test_shift_z();
        send_frame(8'h12, 1'b0);
        send_frame(8'h1A, 1'b0);
        drain(100, "shift_z");
        test_cols(8'hFE, 5'b11010, "shift_z_row0");
        test_cols(8'h00, 5'b11010, "shift_z_all");
        send_frame(8'hF0, 1'b0);
        send_frame(8'h12, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1A, 1'b0);
        drain(100, "shift_z_rel");
        test_cols(8'h00, 5'b11111, "shift_z_released");
    endtask

    task automatic test_extended();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h14, 1'b0);
        drain(100, "ext_ctrl");
        test_cols(8'hFE, 5'b11101, "ext_symshift");
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        drain(100, "ext_ignored");
        test_cols(8'h00, 5'b11101, "ext_ignored_all");
        // 1C after an E0 must not press A
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1C, 1'b0);
        drain(100, "ext_letter");
        test_cols(8'hFD, 5'b11111, "ext_letter_row1");
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h14, 1'b0);
        drain(100, "ext_brk");
        test_cols(8'hFE, 5'b11111, "ext_released");
    endtask

    task automatic test_typematic();
        send_frame(8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0);
        drain(100, "repeat");
        test_cols(8'hFD, 5'b11110, "repeat_held");
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        drain(100, "double_break");
        test_cols(8'hFD, 5'b11111, "double_break_row1");
    endtask

    task automatic test_parity();
        int v0;
        int e0;
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h1C, 1'b1);
        drain(100, "parity");
        checks++;
        if (n_err - e0 != 1 || n_valid - v0 != 0) begin
            errors++;
            $display("FAIL parity_strobes: got err=%0d valid=%0d, expected 1/0",
                     n_err - e0, n_valid - v0);
        end
        test_cols(8'hFD, 5'b11111, "parity_unchanged");
        send_frame(8'h29, 1'b0);
        drain(100, "space");
        test_cols(8'h7F, 5'b11110, "space_row7");
    endtask

    task automatic test_timeout();
        int e0;
        logic [7:0] b;
        e0 = n_err;
        b = 8'h5A;
        exp_q.push_back({1'b0, 1'b1, 8'h00});
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        ps2_data = 1'b1;
        drain(TO_CYC + 300, "timeout");
        checks++;
        if (n_err - e0 != 1) begin
            errors++;
            $display("FAIL timeout_err: got %0d pulses, expected 1", n_err - e0);
        end
        send_frame(8'h5A, 1'b0);
        drain(100, "enter");
        test_cols(8'hBF, 5'b11110, "enter_row6");
    endtask

    task automatic test_reset_mid();
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b0;
        wait_cycles(5);
        ps2_clk = 1'b0;
        wait_cycles(3);
        rst_n = 1'b0;
        test_cols(8'h00, 5'b11111, "rst_mid_cols");
        checks++;
        if (code !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_code: got %02h, expected 00", code);
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(5);
        send_frame(8'h1C, 1'b0);
        drain(100, "after_rst");
        test_cols(8'hFD, 5'b11110, "after_rst_a");
        test_cols(8'hBF, 5'b11111, "after_rst_enter_gone");
    endtask

    initial begin
        rst_n     = 1'b0;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        row_sel_n = 8'hFF;
        #22;
        test_reset();
        test_make_a();
        test_break_a();
        test_shift_z();
        test_extended();
        test_typematic();
        test_parity();
        test_timeout();
        test_reset_mid();
        wait_cycles(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending strobes, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
